// File: rtl/tb_doutb_seq.sv
// tb_doutb_seq: TB port-B read sequencer and TB-to-B mapper control.
// Issues TB reads and delays mapper controls to line up with TB_doutb.
module tb_doutb_seq #(
    parameter int TB_AW           = 10,
    parameter int LEN_DW          = 8,
    parameter int SEQ_CNT_DW      = 5,
    parameter int TB_DOUTB_SEL_DW = 3,
    parameter int RD_LAT          = 1
) (
    input  logic                       clk,
    input  logic                       sys_rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [2:0]                 cmd_op,
    input  logic [TB_AW-1:0]           cmd_base,
    input  logic [LEN_DW-1:0]          cmd_len,
    input  logic                       cmd_l_k_0,
    input  logic                       abort,
    output logic                       TB_enb,
    output logic [TB_AW-1:0]           TB_addrb,
    output logic [TB_DOUTB_SEL_DW-1:0] TB_doutb_sel,
    output logic [SEQ_CNT_DW-1:0]      seq_cnt_dout_sel,
    output logic                       l_k_0,
    output logic                       map_valid,
    output logic                       busy,
    output logic                       done,
    output logic                       cmd_err
);
    localparam int CW = (LEN_DW > 3) ? LEN_DW : 3;
    localparam int DW = $clog2(RD_LAT + 1);
    localparam int SW = TB_DOUTB_SEL_DW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [TB_AW-1:0]    r_base;
    logic [LEN_DW-1:0]   r_len;
    logic                r_lk;
    logic [CW-1:0]       r_cnt;
    logic [DW-1:0]       r_dcnt;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_enb;
    logic [TB_AW-1:0]    r_addr;
    logic [SW-1:0]       r_sel;
    logic [SEQ_CNT_DW-1:0] r_seq;
    logic                r_lkr;
    logic                r_act;

    logic [SW-1:0]         r_dsel [RD_LAT];
    logic [SEQ_CNT_DW-1:0] r_dseq [RD_LAT];
    logic                  r_dlk  [RD_LAT];
    logic                  r_dact [RD_LAT];
    logic                  r_mv;

    logic                  w_accept;
    logic                  w_cache;
    logic                  w_last;
    logic                  w_enb;
    logic [TB_AW-1:0]      w_addr;
    logic [SW-1:0]         w_sel;
    logic [SEQ_CNT_DW-1:0] w_seq;

    function automatic logic [SW-1:0] sel_of(input logic [2:0] op);
        logic [SW-1:0] s;
        s = '0;
        case (op)
            3'd0:    s = SW'(3'b001);
            3'd1:    s = SW'(3'b010);
            3'd2:    s = SW'(3'b011);
            3'd3:    s = SW'(3'b101);
            3'd4:    s = SW'(3'b110);
            3'd5:    s = SW'(3'b111);
            default: s = '0;
        endcase
        return s;
    endfunction

    assign w_accept = cmd_valid & r_ready & ~abort;
    assign w_cache  = (r_op == 3'd4) || (r_op == 3'd5);
    assign w_last   = w_cache ? (r_cnt == CW'(7))
                              : (r_cnt == CW'(r_len) - CW'(1));
    // Cache ops skip the read at counts 0 and 4; low two bits index the triple.
    assign w_enb    = w_cache ? (r_cnt[1:0] != 2'd0) : 1'b1;
    assign w_addr   = w_cache ? (r_base + TB_AW'(r_cnt[1:0]) - TB_AW'(1))
                              : (r_base + TB_AW'(r_cnt));
    assign w_sel    = sel_of(r_op);
    assign w_seq    = w_cache ? SEQ_CNT_DW'(r_cnt[2:0]) : '0;

    // Command FSM with registered read-port and raw mapper controls.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_base  <= '0;
            r_len   <= '0;
            r_lk    <= 1'b0;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_enb   <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_seq   <= '0;
            r_lkr   <= 1'b0;
            r_act   <= 1'b0;
        end else if (abort) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_enb   <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_seq   <= '0;
            r_lkr   <= 1'b0;
            r_act   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_enb  <= 1'b0;
            r_addr <= '0;
            r_sel  <= '0;
            r_seq  <= '0;
            r_lkr  <= 1'b0;
            r_act  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_op    <= cmd_op;
                        r_base  <= cmd_base;
                        r_len   <= cmd_len;
                        r_lk    <= cmd_l_k_0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (cmd_op[2:1] == 2'b11) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (!cmd_op[2] && cmd_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_enb  <= w_enb;
                    r_addr <= w_enb ? w_addr : '0;
                    r_sel  <= w_sel;
                    r_seq  <= w_seq;
                    r_lkr  <= r_lk;
                    r_act  <= 1'b1;
                    r_cnt  <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= S_DRAIN;
                        r_dcnt  <= '0;
                    end
                end
                S_DRAIN: begin
                    r_dcnt <= r_dcnt + DW'(1);
                    if (r_dcnt == DW'(RD_LAT)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Delay line matching the TB read latency, then the mapper valid stage.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n || abort) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_dsel[i] <= '0;
                r_dseq[i] <= '0;
                r_dlk[i]  <= 1'b0;
                r_dact[i] <= 1'b0;
            end
            r_mv <= 1'b0;
        end else begin
            r_dsel[0] <= r_sel;
            r_dseq[0] <= r_seq;
            r_dlk[0]  <= r_lkr;
            r_dact[0] <= r_act;
            for (int i = 1; i < RD_LAT; i++) begin
                r_dsel[i] <= r_dsel[i-1];
                r_dseq[i] <= r_dseq[i-1];
                r_dlk[i]  <= r_dlk[i-1];
                r_dact[i] <= r_dact[i-1];
            end
            r_mv <= r_dact[RD_LAT-1];
        end
    end

    assign cmd_ready        = r_ready;
    assign TB_enb           = r_enb;
    assign TB_addrb         = r_addr;
    assign TB_doutb_sel     = r_dsel[RD_LAT-1];
    assign seq_cnt_dout_sel = r_dseq[RD_LAT-1];
    assign l_k_0            = r_dlk[RD_LAT-1];
    assign map_valid        = r_mv;
    assign busy             = r_busy;
    assign done             = r_done;
    assign cmd_err          = r_err;
endmodule
